// File: rtl/frag_depth_test_if.sv
// Fragment, z-buffer compare/update and result bundle for frag_depth_test.
// slave: the depth-test stage; master: the surrounding fabric or a bench.
interface frag_depth_test_if;
    logic        frag_in_valid;
    logic        frag_in_ready;
    logic [11:0] frag_in_x;
    logic [11:0] frag_in_y;
    logic [31:0] frag_in_z;
    logic [31:0] frag_in_color;
    logic [1:0]  depth_func;
    logic        depth_write_en;

    logic        request_zbuffer_cp;
    logic [23:0] addr_zbuffer_cp;
    logic [31:0] zbuffer_cp;
    logic        zbuffer_valid_cp;
    logic        received_zbuffer_cp;

    logic        request_zbuffer_ud;
    logic [23:0] addr_zbuffer_ud;
    logic [31:0] zbuffer_ud;
    logic        zbuffer_valid_ud;
    logic        received_zbuffer_ud;

    logic        frag_out_valid;
    logic        frag_out_ready;
    logic [11:0] frag_out_x;
    logic [11:0] frag_out_y;
    logic [31:0] frag_out_color;
    logic        frag_out_pass;

    modport slave (
        input  frag_in_valid, frag_in_x, frag_in_y, frag_in_z,
        input  frag_in_color, depth_func, depth_write_en,
        output frag_in_ready,
        output request_zbuffer_cp, addr_zbuffer_cp, received_zbuffer_cp,
        input  zbuffer_cp, zbuffer_valid_cp,
        output request_zbuffer_ud, addr_zbuffer_ud, zbuffer_ud,
        output received_zbuffer_ud,
        input  zbuffer_valid_ud,
        output frag_out_valid, frag_out_x, frag_out_y,
        output frag_out_color, frag_out_pass,
        input  frag_out_ready
    );

    modport master (
        output frag_in_valid, frag_in_x, frag_in_y, frag_in_z,
        output frag_in_color, depth_func, depth_write_en,
        input  frag_in_ready,
        input  request_zbuffer_cp, addr_zbuffer_cp, received_zbuffer_cp,
        output zbuffer_cp, zbuffer_valid_cp,
        input  request_zbuffer_ud, addr_zbuffer_ud, zbuffer_ud,
        input  received_zbuffer_ud,
        output zbuffer_valid_ud,
        input  frag_out_valid, frag_out_x, frag_out_y,
        input  frag_out_color, frag_out_pass,
        output frag_out_ready
    );
endinterface

// File: rtl/frag_depth_test.sv
// Per-fragment depth test: read stored z, compare, optionally write, emit.
// Ports: clk, rst_n (async low), bus (frag_depth_test_if.slave);
// with FRAG_DEPTH_STATS_EN defined also stat_tested/stat_passed counters.
module frag_depth_test #(
    parameter int unsigned FB_WIDTH  = 640,
    parameter logic [23:0] ZBUF_BASE = 24'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frag_depth_test_if.slave     bus
`ifdef FRAG_DEPTH_STATS_EN
    ,
    output logic [31:0]          stat_tested,
    output logic [31:0]          stat_passed
`endif
);

    localparam logic [1:0] F_LESS   = 2'd0;
    localparam logic [1:0] F_LEQUAL = 2'd1;
    localparam logic [1:0] F_ALWAYS = 2'd2;
    localparam logic [1:0] F_NEVER  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_ACK,
        S_CMP,
        S_WR_REQ,
        S_WR_ACK,
        S_OUT
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [31:0] z_q, z_d;
    logic [31:0] zs_q, zs_d;
    logic [31:0] col_q, col_d;
    logic [23:0] addr_q, addr_d;
    logic [1:0]  func_q, func_d;
    logic        wen_q, wen_d;
    logic        pass_q, pass_d;

    // Row-major word address, naturally wrapping at 24 bits.
    logic [23:0] addr_in;
    assign addr_in = ZBUF_BASE
                   + 24'(bus.frag_in_y) * 24'(FB_WIDTH)
                   + 24'(bus.frag_in_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zs_q    <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            func_q  <= '0;
            wen_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zs_q    <= zs_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            func_q  <= func_d;
            wen_q   <= wen_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zs_d    = zs_q;
        col_d   = col_q;
        addr_d  = addr_q;
        func_d  = func_q;
        wen_d   = wen_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.frag_in_valid) begin
                    x_d    = bus.frag_in_x;
                    y_d    = bus.frag_in_y;
                    z_d    = bus.frag_in_z;
                    col_d  = bus.frag_in_color;
                    addr_d = addr_in;
                    func_d = bus.depth_func;
                    wen_d  = bus.depth_write_en;
                    unique case (1'b1)
                        bus.depth_func == F_NEVER: begin
                            pass_d  = 1'b0;
                            state_d = S_OUT;
                        end
                        bus.depth_func == F_ALWAYS: begin
                            pass_d  = 1'b1;
                            state_d = bus.depth_write_en ? S_WR_REQ : S_OUT;
                        end
                        default: begin
                            state_d = S_RD_REQ;
                        end
                    endcase
                end
            end
            S_RD_REQ: begin
                if (bus.zbuffer_valid_cp) begin
                    zs_d    = bus.zbuffer_cp;
                    state_d = S_RD_ACK;
                end
            end
            S_RD_ACK: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                // Only LESS and LEQUAL ever reach the compare.
                pass_d  = (func_q == F_LESS) ? (z_q < zs_q) : (z_q <= zs_q);
                state_d = (pass_d && wen_q) ? S_WR_REQ : S_OUT;
            end
            S_WR_REQ: begin
                if (bus.zbuffer_valid_ud) begin
                    state_d = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.frag_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs; requests drop during the ack cycle so the arbiter
    // does not see a fresh request while it retires the old one.
    assign bus.frag_in_ready       = (state_q == S_IDLE);
    assign bus.request_zbuffer_cp  = (state_q == S_RD_REQ);
    assign bus.received_zbuffer_cp = (state_q == S_RD_ACK);
    assign bus.addr_zbuffer_cp     = addr_q;
    assign bus.request_zbuffer_ud  = (state_q == S_WR_REQ);
    assign bus.received_zbuffer_ud = (state_q == S_WR_ACK);
    assign bus.addr_zbuffer_ud     = addr_q;
    assign bus.zbuffer_ud          = z_q;
    assign bus.frag_out_valid      = (state_q == S_OUT);
    assign bus.frag_out_x          = x_q;
    assign bus.frag_out_y          = y_q;
    assign bus.frag_out_color      = col_q;
    assign bus.frag_out_pass       = pass_q;

`ifdef FRAG_DEPTH_STATS_EN
    logic        out_hs;
    logic [31:0] tested_q;
    logic [31:0] passed_q;

    assign out_hs = (state_q == S_OUT) && bus.frag_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tested_q <= '0;
            passed_q <= '0;
        end else if (out_hs) begin
            tested_q <= tested_q + 32'd1;
            passed_q <= passed_q + {31'd0, pass_q};
        end
    end

    assign stat_tested = tested_q;
    assign stat_passed = passed_q;
`else
    wire unused_func_leq = (func_q == F_LEQUAL);
`endif

endmodule

// File: tb/tb_frag_depth_test.sv
// Randomised bench for frag_depth_test against a z-buffer memory model.
// Checks addresses, pass flag, channel traffic, latency and hold behaviour.
module tb_frag_depth_test;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frag_depth_test_if bus();

`ifdef FRAG_DEPTH_STATS_EN
    logic [31:0] st_tested;
    logic [31:0] st_passed;
`endif

    frag_depth_test #(
        .FB_WIDTH (640),
        .ZBUF_BASE(24'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef FRAG_DEPTH_STATS_EN
        ,
        .stat_tested(st_tested),
        .stat_passed(st_passed)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    int n_pass = 0;
    logic [31:0] zmem [int];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.frag_in_valid    = 1'b0;
        bus.frag_in_x        = '0;
        bus.frag_in_y        = '0;
        bus.frag_in_z        = '0;
        bus.frag_in_color    = '0;
        bus.depth_func       = '0;
        bus.depth_write_en   = 1'b0;
        bus.zbuffer_cp       = '0;
        bus.zbuffer_valid_cp = 1'b0;
        bus.zbuffer_valid_ud = 1'b0;
        bus.frag_out_ready   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.frag_in_ready), 64'd1);
        chk({tag, "_req_cp"}, 64'(bus.request_zbuffer_cp), 64'd0);
        chk({tag, "_rcv_cp"}, 64'(bus.received_zbuffer_cp), 64'd0);
        chk({tag, "_addr_cp"}, 64'(bus.addr_zbuffer_cp), 64'd0);
        chk({tag, "_req_ud"}, 64'(bus.request_zbuffer_ud), 64'd0);
        chk({tag, "_rcv_ud"}, 64'(bus.received_zbuffer_ud), 64'd0);
        chk({tag, "_addr_ud"}, 64'(bus.addr_zbuffer_ud), 64'd0);
        chk({tag, "_data_ud"}, 64'(bus.zbuffer_ud), 64'd0);
        chk({tag, "_out_valid"}, 64'(bus.frag_out_valid), 64'd0);
        chk({tag, "_out_x"}, 64'(bus.frag_out_x), 64'd0);
        chk({tag, "_out_y"}, 64'(bus.frag_out_y), 64'd0);
        chk({tag, "_out_col"}, 64'(bus.frag_out_color), 64'd0);
        chk({tag, "_out_pass"}, 64'(bus.frag_out_pass), 64'd0);
    endtask

    // One fragment end to end. dr/dw: extra request cycles before the
    // memory answers; hold: cycles the result is back-pressured.
    task automatic run_frag(input logic [11:0] x, input logic [11:0] y,
                            input logic [31:0] z, input logic [31:0] col,
                            input logic [1:0] f, input logic wen,
                            input int dr, input int dw, input int hold);
        int          a;
        logic [31:0] zs;
        logic        e_rd, e_pass, e_wr;
        int          lat, cyc, w, rd_n, wr_n, rd_ack, wr_ack;
        logic        done;
        a = (int'(y) * 640 + int'(x)) % (1 << 24);
        e_rd = (f == 2'd0) || (f == 2'd1);
        zs = 32'd0;
        if (e_rd) begin
            if (!zmem.exists(a)) zmem[a] = 32'($urandom_range(0, 15));
            zs = zmem[a];
        end
        case (f)
            2'd0:    e_pass = (z < zs);
            2'd1:    e_pass = (z <= zs);
            2'd2:    e_pass = 1'b1;
            default: e_pass = 1'b0;
        endcase
        e_wr = e_pass && wen;
        lat = 1 + (e_rd ? 3 + dr : 0) + (e_wr ? 2 + dw : 0);

        w = 0;
        while (!bus.frag_in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before_accept", 64'(bus.frag_in_ready), 64'd1);
        bus.frag_in_valid  = 1'b1;
        bus.frag_in_x      = x;
        bus.frag_in_y      = y;
        bus.frag_in_z      = z;
        bus.frag_in_color  = col;
        bus.depth_func     = f;
        bus.depth_write_en = wen;

        cyc = 0; rd_n = 0; wr_n = 0; rd_ack = 0; wr_ack = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.frag_in_valid    = 1'b0;
            bus.zbuffer_valid_cp = 1'b0;
            bus.zbuffer_valid_ud = 1'b0;
            if (bus.request_zbuffer_cp) begin
                if (rd_n == 0)
                    chk("cp_addr", 64'(bus.addr_zbuffer_cp), 64'(a));
                if (rd_n == dr) begin
                    bus.zbuffer_valid_cp = 1'b1;
                    bus.zbuffer_cp       = zs;
                end
                rd_n++;
            end
            if (bus.received_zbuffer_cp) begin
                rd_ack++;
                chk("cp_req_low_in_ack", 64'(bus.request_zbuffer_cp), 64'd0);
            end
            if (bus.request_zbuffer_ud) begin
                if (wr_n == 0) begin
                    chk("ud_addr", 64'(bus.addr_zbuffer_ud), 64'(a));
                    chk("ud_data", 64'(bus.zbuffer_ud), 64'(z));
                end
                if (wr_n == dw) bus.zbuffer_valid_ud = 1'b1;
                wr_n++;
            end
            if (bus.received_zbuffer_ud) begin
                wr_ack++;
                chk("ud_req_low_in_ack", 64'(bus.request_zbuffer_ud), 64'd0);
            end
            if (bus.frag_out_valid) done = 1'b1;
        end
        bus.zbuffer_valid_cp = 1'b0;
        bus.zbuffer_valid_ud = 1'b0;

        chk("out_valid_seen", 64'(done), 64'd1);
        chk("latency", 64'(cyc), 64'(lat));
        chk("cp_requested", 64'(rd_n > 0), 64'(e_rd));
        chk("cp_ack_count", 64'(rd_ack), 64'(e_rd));
        chk("ud_requested", 64'(wr_n > 0), 64'(e_wr));
        chk("ud_ack_count", 64'(wr_ack), 64'(e_wr));
        chk("out_x", 64'(bus.frag_out_x), 64'(x));
        chk("out_y", 64'(bus.frag_out_y), 64'(y));
        chk("out_color", 64'(bus.frag_out_color), 64'(col));
        chk("out_pass", 64'(bus.frag_out_pass), 64'(e_pass));
        if (e_wr) zmem[a] = z;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.frag_out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.frag_in_ready), 64'd0);
            chk("hold_x", 64'(bus.frag_out_x), 64'(x));
            chk("hold_y", 64'(bus.frag_out_y), 64'(y));
            chk("hold_color", 64'(bus.frag_out_color), 64'(col));
            chk("hold_pass", 64'(bus.frag_out_pass), 64'(e_pass));
        end
        bus.frag_out_ready = 1'b1;
        @(negedge clk);
        bus.frag_out_ready = 1'b0;
        n_out++;
        if (e_pass) n_pass++;
        chk("out_valid_after_hs", 64'(bus.frag_out_valid), 64'd0);
        chk("in_ready_after_hs", 64'(bus.frag_in_ready), 64'd1);
    endtask

    // Reset while waiting for read data, then a stray read pulse in IDLE.
    task automatic reset_mid_read();
        int w;
        bus.frag_in_valid = 1'b1;
        bus.frag_in_x     = 12'd5;
        bus.frag_in_y     = 12'd1;
        bus.frag_in_z     = 32'h7;
        bus.frag_in_color = 32'hDEAD_BEEF;
        bus.depth_func    = 2'd0;
        bus.depth_write_en = 1'b1;
        @(negedge clk);
        bus.frag_in_valid = 1'b0;
        w = 0;
        while (!bus.request_zbuffer_cp && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid_in_rd_req", 64'(bus.request_zbuffer_cp), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        n_out = 0;
        n_pass = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.zbuffer_valid_cp = 1'b1;
        bus.zbuffer_cp       = 32'h1234;
        @(negedge clk);
        bus.zbuffer_valid_cp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stray_in_ready", 64'(bus.frag_in_ready), 64'd1);
            chk("stray_rcv_cp", 64'(bus.received_zbuffer_cp), 64'd0);
            chk("stray_out_valid", 64'(bus.frag_out_valid), 64'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        zmem[32'h503] = 32'h200;
        run_frag(12'd3, 12'd2, 32'h100, 32'hC0FFEE, 2'd0, 1'b1, 2, 0, 0);
        chk("zmem_written", 64'(zmem[32'h503]), 64'h100);

        zmem[16] = 32'h200;
        run_frag(12'd16, 12'd0, 32'h200, 32'h11, 2'd0, 1'b1, 0, 0, 0);
        run_frag(12'd16, 12'd0, 32'h200, 32'h22, 2'd1, 1'b1, 0, 1, 0);
        run_frag(12'd7, 12'd9, 32'h5, 32'h33, 2'd3, 1'b1, 0, 0, 0);
        run_frag(12'd8, 12'd9, 32'h5, 32'h44, 2'd2, 1'b0, 0, 0, 0);
        run_frag(12'd9, 12'd9, 32'h5, 32'h55, 2'd2, 1'b1, 0, 0, 0);
        run_frag(12'd4095, 12'd4095, 32'h0, 32'h66, 2'd0, 1'b0, 1, 0, 5);

        reset_mid_read();

        for (int i = 0; i < 150; i++) begin
            run_frag(12'($urandom_range(0, 7)), 12'($urandom_range(0, 3)),
                     32'($urandom_range(0, 15)), 32'($urandom),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
        end

`ifdef FRAG_DEPTH_STATS_EN
        chk("stat_tested", 64'(st_tested), 64'(n_out));
        chk("stat_passed", 64'(st_passed), 64'(n_pass));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
